// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer
//   Data-memory responder for a single-cycle CPU data port. CPU stores are
//   posted into a small FIFO and drained in order to a slower backing memory
//   over a req/gnt bus. Loads are forwarded from the FIFO on a hit (youngest
//   matching entry wins) or fetched from backing memory on a miss. Stall holds
//   the CPU while the data port cannot complete the current access.
//
// Ports
//   Clk, Clrn            clock, asynchronous active-low reset
//   Daddr/Dwrite         CPU word address (bits [1:0] ignored) and store data
//   Wmem/Rmem            CPU store / load strobes (store wins if both set)
//   Dread, Stall         load data and CPU hold request
//   mem_req/we/addr/wdata  backing-bus request side
//   mem_gnt              request accepted at the edge where mem_req && mem_gnt
//   mem_rvalid/rdata     one-cycle read return

module dmem_write_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic [31:0] Daddr,
  input  logic [31:0] Dwrite,
  input  logic        Wmem,
  input  logic        Rmem,
  output logic [31:0] Dread,
  output logic        Stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StWreq  = 3'd1;
  localparam logic [2:0] StRreq  = 3'd2;
  localparam logic [2:0] StRwait = 3'd3;
  localparam logic [2:0] StRdone = 3'd4;

  logic [29:0]   r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [2:0]    r_state;
  logic [31:0]   r_rdata;

  logic [2:0]    w_state_nxt;
  logic          w_full;
  logic          w_load;
  logic          w_hit;
  logic [31:0]   w_hit_data;
  logic          w_miss;
  logic          w_push;
  logic          w_pop;
  logic          w_unused_addr;

  assign w_unused_addr = ^Daddr[1:0];

  assign w_full = (r_count == CW'(DEPTH));
  // Store wins when both strobes are set.
  assign w_load = Rmem && !Wmem;
  assign w_miss = w_load && !w_hit;
  assign w_push = Wmem && !w_full;
  assign w_pop  = (r_state == StWreq) && mem_gnt;

  // Scan oldest to youngest so the last match is the youngest entry. The head
  // is included even while it is on the bus, since it is not popped until gnt.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < r_count) && (r_addr[r_head + PW'(i)] == Daddr[31:2])) begin
        w_hit      = 1'b1;
        w_hit_data = r_data[r_head + PW'(i)];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: begin
        if (w_miss) begin
          w_state_nxt = StRreq;
        end else if (r_count != '0) begin
          w_state_nxt = StWreq;
        end
      end
      StWreq:  if (mem_gnt) w_state_nxt = StIdle;
      StRreq:  if (mem_gnt) w_state_nxt = StRwait;
      StRwait: if (mem_rvalid) w_state_nxt = StRdone;
      StRdone: w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_state <= StIdle;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
      if ((r_state == StRwait) && mem_rvalid) r_rdata <= mem_rdata;
    end
  end

  // Entry storage needs no reset: validity comes from r_count.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_addr[r_tail] <= Daddr[31:2];
      r_data[r_tail] <= Dwrite;
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (r_state == StWreq) begin
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = {r_addr[r_head], 2'b00};
      mem_wdata = r_data[r_head];
    end else if (r_state == StRreq) begin
      // CPU holds Daddr while stalled, so this stays stable until gnt.
      mem_req  = 1'b1;
      mem_addr = {Daddr[31:2], 2'b00};
    end
  end

  assign Stall = (Wmem && w_full)
               || (w_miss && ((r_state == StIdle) || (r_state == StWreq)))
               || (r_state == StRreq) || (r_state == StRwait);

  always_comb begin
    if (r_state == StRdone) begin
      Dread = r_rdata;
    end else if (w_load && w_hit) begin
      Dread = w_hit_data;
    end else begin
      Dread = '0;
    end
  end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Bench for dmem_write_buffer: directed stimulus with a write scoreboard.
// Every store pushes {addr, data} into exp_q; a bus monitor pops and compares
// on each accepted write request.

module tb_dmem_write_buffer;

  logic        Clk;
  logic        Clrn;
  logic [31:0] Daddr;
  logic [31:0] Dwrite;
  logic        Wmem;
  logic        Rmem;
  logic [31:0] Dread;
  logic        Stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_vec = 0;
  int n_bad = 0;

  logic [63:0] exp_q[$];

  dmem_write_buffer #(.DEPTH(4)) dut (
    .Clk        (Clk),
    .Clrn       (Clrn),
    .Daddr      (Daddr),
    .Dwrite     (Dwrite),
    .Wmem       (Wmem),
    .Rmem       (Rmem),
    .Dread      (Dread),
    .Stall      (Stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Accepted write: mem_req && mem_we && mem_gnt seen between edges.
  always @(negedge Clk) begin
    if (Clrn && mem_req && mem_we && mem_gnt) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("wr_addr", mem_addr, e[63:32]);
        check("wr_data", mem_wdata, e[31:0]);
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    Wmem  = 1'b0;
    Rmem  = 1'b0;
    Daddr = '0;
    Dwrite = '0;
  endtask

  // Drive a store for one edge; expects the FIFO has room.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    Wmem   = 1'b1;
    Rmem   = 1'b0;
    Daddr  = a;
    Dwrite = d;
    exp_q.push_back({a, d});
    #1;
    check("store_nostall", {31'd0, Stall}, 32'd0);
    step();
    Wmem = 1'b0;
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    mem_gnt = 1'b1;
    while ((exp_q.size() != 0 || mem_req) && cyc < 60) begin
      step();
      cyc++;
    end
    mem_gnt = 1'b0;
    check("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Clrn       = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    idle_inputs();
    step();
    step();
    check("rst_stall", {31'd0, Stall}, 32'd0);
    check("rst_dread", Dread, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    Clrn = 1'b1;
    step();

    // 1: reset mid-run abandons the queued store.
    store(32'h100, 32'hAA);
    step();
    Clrn = 1'b0;
    #1;
    check("t1_stall", {31'd0, Stall}, 32'd0);
    check("t1_dread", Dread, 32'd0);
    check("t1_req", {31'd0, mem_req}, 32'd0);
    exp_q.delete();
    #2;
    Clrn = 1'b1;
    step();
    store(32'h104, 32'h55);
    Rmem = 1'b1; Daddr = 32'h104;
    #1;
    check("t1_hit", Dread, 32'h55);
    Daddr = 32'h100;
    #1;
    check("t1_old_miss", {31'd0, Stall}, 32'd1);
    Rmem = 1'b0;
    drain();

    // 2: forward from a pending store, then drain it.
    store(32'h10, 32'hDEADBEEF);
    Rmem = 1'b1; Daddr = 32'h10;
    #1;
    check("t2_dread", Dread, 32'hDEADBEEF);
    check("t2_stall", {31'd0, Stall}, 32'd0);
    step();
    Rmem = 1'b0;
    check("t2_req", {31'd0, mem_req}, 32'd1);
    check("t2_we", {31'd0, mem_we}, 32'd1);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    check("t2_popped", 32'(exp_q.size()), 32'd0);
    check("t2_req_low", {31'd0, mem_req}, 32'd0);

    // 3: full FIFO stalls a store until one entry drains.
    for (int i = 0; i < 4; i++) store(32'(4 * i), 32'hA0 + 32'(i));
    Wmem = 1'b1; Daddr = 32'h14; Dwrite = 32'hA5;
    exp_q.push_back({32'h14, 32'hA5});
    #1;
    check("t3_full_stall", {31'd0, Stall}, 32'd1);
    step();
    check("t3_still_stall", {31'd0, Stall}, 32'd1);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    check("t3_stall_fall", {31'd0, Stall}, 32'd0);
    check("t3_first_out", 32'(exp_q.size()), 32'd4);
    step();
    Wmem = 1'b0;
    drain();

    // 4: load miss through the full read handshake.
    Rmem = 1'b1; Daddr = 32'h40;
    #1;
    check("t4_miss_stall", {31'd0, Stall}, 32'd1);
    step();
    check("t4_rreq", {31'd0, mem_req}, 32'd1);
    check("t4_rwe", {31'd0, mem_we}, 32'd0);
    check("t4_raddr", mem_addr, 32'h40);
    step();
    check("t4_req_hold", {31'd0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    check("t4_rwait_req", {31'd0, mem_req}, 32'd0);
    check("t4_rwait_stall", {31'd0, Stall}, 32'd1);
    step();
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    step();
    mem_rvalid = 1'b0; mem_rdata = 32'hFFFFFFFF;
    check("t4_rdone_data", Dread, 32'h12345678);
    check("t4_rdone_stall", {31'd0, Stall}, 32'd0);
    step();
    Rmem = 1'b0;
    #1;
    check("t4_after_dread", Dread, 32'd0);
    check("t4_after_req", {31'd0, mem_req}, 32'd0);

    // 5: duplicate addresses, youngest forwarded, both drain in order.
    store(32'h20, 32'h1);
    store(32'h20, 32'h2);
    Rmem = 1'b1; Daddr = 32'h20;
    #1;
    check("t5_youngest", Dread, 32'h2);
    check("t5_stall", {31'd0, Stall}, 32'd0);
    Rmem = 1'b0;
    drain();

    // 6: reset during RWAIT; the late rvalid must be ignored.
    Rmem = 1'b1; Daddr = 32'h80;
    step();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    step();
    Clrn = 1'b0;
    idle_inputs();
    #1;
    check("t6_req", {31'd0, mem_req}, 32'd0);
    check("t6_stall", {31'd0, Stall}, 32'd0);
    #2;
    Clrn = 1'b1;
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_rvalid = 1'b0;
    check("t6_dread", Dread, 32'd0);
    check("t6_idle_req", {31'd0, mem_req}, 32'd0);
    step();
    check("t6_empty_req", {31'd0, mem_req}, 32'd0);
    Rmem = 1'b1; Daddr = 32'h80;
    #1;
    check("t6_miss_again", {31'd0, Stall}, 32'd1);
    Rmem = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
